branch_fb_sched: RTL and testbench

BRANCH_FB_SCHED -- requirements
Module: branch_fb_sched

---
 rtl/core.sv | 12 +
 rtl/branch_fb_sched.sv | 89 ++++++++
 tb/tb_branch_fb_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/core.sv
// Shared core types used by the branch feedback path and the predictor.
package core;

  localparam int peval_width = 2;

  typedef struct packed {
    logic        valid;
    logic [31:0] base_pc;
    logic        branch_taken;
  } branch_pred_fb_t;

endpackage

// File: rtl/branch_fb_sched.sv
// Collects per-lane branch resolutions into a FIFO and serializes them,
// one per cycle, toward the branch predictor.
module branch_fb_sched #(
  parameter int fifo_depth = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            hold,
  input  core::branch_pred_fb_t           res [core::peval_width],
  output logic                            res_ready,
  output core::branch_pred_fb_t           fb,
  output logic                            pred_en,
  output logic [$clog2(fifo_depth):0]     occupancy
);

  localparam int PTR_W = $clog2(fifo_depth);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  core::branch_pred_fb_t mem_q [fifo_depth];
  core::branch_pred_fb_t mem_d [fifo_depth];
  ptr_t                  wr_ptr_q, wr_ptr_d;
  ptr_t                  rd_ptr_q, rd_ptr_d;
  cnt_t                  cnt_q, cnt_d;
  core::branch_pred_fb_t fb_q, fb_d;
  cnt_t                  n_enq;
  logic                  do_deq;

  // Room for a full lane group is judged from registered state only, so
  // upstream can act on res_ready without a combinational loop through res.
  assign res_ready = (cnt_t'(fifo_depth) - cnt_q) >= cnt_t'(core::peval_width);
  assign pred_en   = !hold;
  assign occupancy = cnt_q;
  assign fb        = fb_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    fb_d     = '0;
    n_enq    = '0;
    do_deq   = 1'b0;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      do_deq = !hold && (cnt_q != '0);
      if (do_deq) begin
        fb_d       = mem_q[rd_ptr_q];
        fb_d.valid = 1'b1;
        rd_ptr_d   = rd_ptr_q + ptr_t'(1);
      end
      // Compact valid lanes in ascending order; the write pointer advances
      // only on valid lanes so holes never reach the predictor.
      if (res_ready) begin
        for (int i = 0; i < core::peval_width; i++) begin
          if (res[i].valid) begin
            mem_d[wr_ptr_d] = res[i];
            wr_ptr_d        = wr_ptr_d + ptr_t'(1);
            n_enq           = n_enq + cnt_t'(1);
          end
        end
      end
      cnt_d = cnt_q + n_enq - cnt_t'(do_deq);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      fb_q     <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      fb_q     <= fb_d;
    end
  end

endmodule

// File: tb/tb_branch_fb_sched.sv
// Randomized and directed checks of branch_fb_sched against a queue model.
module tb_branch_fb_sched;

  localparam int DEPTH = 8;
  localparam int W     = core::peval_width;

  logic                  clk;
  logic                  rst;
  logic                  flush;
  logic                  hold;
  core::branch_pred_fb_t res [W];
  logic                  res_ready;
  core::branch_pred_fb_t fb;
  logic                  pred_en;
  logic [3:0]            occupancy;

  branch_fb_sched #(.fifo_depth(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .hold      (hold),
    .res       (res),
    .res_ready (res_ready),
    .fb        (fb),
    .pred_en   (pred_en),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  core::branch_pred_fb_t mq[$];
  core::branch_pred_fb_t exp_fb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    exp_fb = '0;
  endtask

  // Abstract behaviour at one clock edge: flush empties everything; otherwise
  // the head leaves unless held, and a whole group enters if space was free.
  task automatic model_edge();
    bit ready;
    if (flush) begin
      mq.delete();
      exp_fb = '0;
    end else begin
      ready  = (DEPTH - mq.size()) >= W;
      exp_fb = '0;
      if (!hold && mq.size() > 0) begin
        exp_fb       = mq.pop_front();
        exp_fb.valid = 1'b1;
      end
      if (ready)
        for (int i = 0; i < W; i++)
          if (res[i].valid) mq.push_back(res[i]);
    end
  endtask

  task automatic compare();
    check("occupancy", 64'(occupancy), 64'(mq.size()));
    check("occ_bound", 64'(occupancy <= DEPTH), 64'd1);
    check("res_ready", 64'(res_ready), 64'((DEPTH - mq.size()) >= W));
    check("pred_en", 64'(pred_en), 64'(!hold));
    check("fb_valid", 64'(fb.valid), 64'(exp_fb.valid));
    if (exp_fb.valid) begin
      check("fb_pc", 64'(fb.base_pc), 64'(exp_fb.base_pc));
      check("fb_taken", 64'(fb.branch_taken), 64'(exp_fb.branch_taken));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_res(input logic v0, input logic [31:0] p0, input logic t0,
                         input logic v1, input logic [31:0] p1, input logic t1);
    res[0].valid = v0; res[0].base_pc = p0; res[0].branch_taken = t0;
    res[1].valid = v1; res[1].base_pc = p1; res[1].branch_taken = t1;
  endtask

  task automatic rand_res(input int pct);
    for (int i = 0; i < W; i++) begin
      res[i].valid        = ($urandom_range(99) < pct);
      res[i].base_pc      = $urandom & 32'hffff_fffc;
      res[i].branch_taken = 1'($urandom);
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    set_res(0, 0, 0, 0, 0, 0);
    model_reset();
    @(posedge clk); @(posedge clk); @(negedge clk);
    check("rst_occ", 64'(occupancy), 64'd0);
    check("rst_fb", 64'(fb), 64'd0);
    rst = 1'b0;
    compare();

    // Two lanes in one group, then drain.
    set_res(1, 32'h10, 1, 1, 32'h14, 0);
    step();
    set_res(0, 0, 0, 0, 0, 0);
    repeat (4) step();

    // Only lane 1 valid.
    set_res(0, 0, 0, 1, 32'h20, 1);
    step();
    set_res(0, 0, 0, 0, 0, 0);
    repeat (3) step();

    // Fill under hold; the fifth group must be refused.
    hold = 1'b1;
    for (int g = 0; g < 5; g++) begin
      set_res(1, 32'h100 + 32'(g * 8), 1, 1, 32'h104 + 32'(g * 8), 0);
      step();
    end
    check("full_occ", 64'(occupancy), 64'd8);
    check("full_ready", 64'(res_ready), 64'd0);
    set_res(0, 0, 0, 0, 0, 0);
    hold = 1'b0;
    repeat (10) step();

    // Sustained two per cycle with pointer wrap.
    for (int c = 0; c < 24; c++) begin
      rand_res(100);
      step();
    end
    set_res(0, 0, 0, 0, 0, 0);
    repeat (10) step();

    // Occupancy 5, then flush with a valid group that must be dropped.
    hold = 1'b1;
    set_res(1, 32'h200, 0, 1, 32'h204, 1); step();
    set_res(1, 32'h208, 1, 1, 32'h20c, 0); step();
    set_res(1, 32'h210, 1, 0, 0, 0);       step();
    check("pre_flush_occ", 64'(occupancy), 64'd5);
    flush = 1'b1;
    set_res(1, 32'hdead0, 1, 1, 32'hdead4, 1);
    step();
    flush = 1'b0; hold = 1'b0;
    set_res(0, 0, 0, 0, 0, 0);
    check("flush_occ", 64'(occupancy), 64'd0);
    check("flush_fbv", 64'(fb.valid), 64'd0);
    repeat (3) step();

    // Asynchronous reset between edges with three entries queued.
    hold = 1'b1;
    set_res(1, 32'h300, 1, 1, 32'h304, 1); step();
    set_res(1, 32'h308, 0, 0, 0, 0);       step();
    set_res(0, 0, 0, 0, 0, 0);
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    #2 rst = 1'b1;
    #1;
    check("async_occ", 64'(occupancy), 64'd0);
    check("async_fb", 64'(fb), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0; hold = 1'b0;
    repeat (3) step();

    // Random traffic with occasional hold and flush.
    for (int c = 0; c < 400; c++) begin
      flush = ($urandom_range(29) == 0);
      hold  = ($urandom_range(3) == 0);
      rand_res(70);
      step();
    end
    flush = 1'b0; hold = 1'b0;
    set_res(0, 0, 0, 0, 0, 0);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
